// File: rtl/vid_issue_stage.sv
// Decode/issue stage for the 64-bit SIMD pipeline: decodes fetch instructions,
// reads the 32x64 register file with writeback bypass, and stalls on busy-bit hazards.
module vid_issue_stage #(
    parameter int NREGS = 32,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_valid,
    input  logic [0:31]   if_instr,
    output logic          id_ready,
    input  logic          flush,
    input  logic          wb_en,
    input  logic [0:4]    wb_addr,
    input  logic [0:DW-1] wb_data,
    input  logic          ex_ready,
    output logic          ex_valid,
    output logic [0:DW-1] ex_rA_val,
    output logic [0:DW-1] ex_rB_val,
    output logic [0:5]    ex_Op_code,
    output logic [0:5]    ex_R_ins,
    output logic [0:1]    ex_WW,
    output logic [0:4]    ex_rD,
    output logic          ex_wr_en,
    output logic [0:15]   ex_imm
);
    localparam logic [5:0] OP_RALU = 6'b101010;
    localparam logic [5:0] OP_LOAD = 6'b100000;
    localparam logic [5:0] OP_STOR = 6'b100001;
    localparam logic [5:0] OP_BREZ = 6'b100010;
    localparam logic [5:0] OP_BRNZ = 6'b100011;
    localparam logic [5:0] OP_NOP  = 6'b111100;

    logic [DW-1:0]    rf_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;

    logic          ex_valid_q, ex_wr_en_q;
    logic [DW-1:0] ex_ra_q, ex_rb_q;
    logic [5:0]    ex_op_q, ex_func_q;
    logic [1:0]    ex_ww_q;
    logic [4:0]    ex_rd_q;
    logic [15:0]   ex_imm_q;

    logic [5:0]  dec_op, dec_func;
    logic [4:0]  dec_rd, dec_ra, dec_rb, src1;
    logic [1:0]  dec_ww;
    logic [15:0] dec_imm;
    logic        is_ralu, is_load, is_stbr, dec_wr_en, use1, use2;
    logic        hazard, advance, issue;
    logic [DW-1:0] src1_val, src2_val;

    assign dec_op   = if_instr[0:5];
    assign dec_rd   = if_instr[6:10];
    assign dec_ra   = if_instr[11:15];
    assign dec_rb   = if_instr[16:20];
    assign dec_ww   = if_instr[24:25];
    assign dec_func = if_instr[26:31];
    assign dec_imm  = if_instr[16:31];

    assign is_ralu   = (dec_op == OP_RALU);
    assign is_load   = (dec_op == OP_LOAD);
    assign is_stbr   = (dec_op == OP_STOR) || (dec_op == OP_BREZ) || (dec_op == OP_BRNZ);
    assign dec_wr_en = ((is_ralu && dec_func != 6'd0) || is_load) && (dec_rd != 5'd0);
    assign use1      = is_ralu || is_stbr;
    assign use2      = is_ralu;
    assign src1      = is_ralu ? dec_ra : dec_rd;

    // Write-first read: a same-cycle writeback to the source wins over the array.
    function automatic logic [DW-1:0] read_reg(input logic [4:0] a);
        if (a == 5'd0)
            return '0;
        else if (wb_en && (wb_addr == a))
            return wb_data;
        else
            return rf_q[a];
    endfunction

    // A busy bit being cleared by this cycle's writeback no longer blocks issue.
    function automatic logic still_busy(input logic [4:0] a);
        return (a != 5'd0) && busy_q[a] && !(wb_en && (wb_addr == a));
    endfunction

    assign src1_val = use1 ? read_reg(src1) : '0;
    assign src2_val = use2 ? read_reg(dec_rb) : '0;

    assign hazard  = if_valid && ((use1 && still_busy(src1)) ||
                                  (use2 && still_busy(dec_rb)) ||
                                  (dec_wr_en && still_busy(dec_rd)));
    assign advance  = !ex_valid_q || ex_ready;
    assign id_ready = advance && !hazard && !flush;
    assign issue    = id_ready && if_valid;

    always_comb begin
        busy_d = busy_q;
        if (wb_en)
            busy_d[wb_addr] = 1'b0;
        if (flush && ex_valid_q && ex_wr_en_q)
            busy_d[ex_rd_q] = 1'b0;
        if (issue && dec_wr_en)
            busy_d[dec_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                rf_q[i] <= '0;
            busy_q <= '0;
        end else begin
            if (wb_en && (wb_addr != 5'd0))
                rf_q[wb_addr] <= wb_data;
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_wr_en_q <= 1'b0;
            ex_ra_q    <= '0;
            ex_rb_q    <= '0;
            ex_op_q    <= OP_NOP;
            ex_func_q  <= '0;
            ex_ww_q    <= '0;
            ex_rd_q    <= '0;
            ex_imm_q   <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
            ex_wr_en_q <= 1'b0;
        end else if (advance) begin
            ex_valid_q <= issue;
            ex_wr_en_q <= issue && dec_wr_en;
            ex_ra_q    <= src1_val;
            ex_rb_q    <= src2_val;
            ex_op_q    <= dec_op;
            ex_func_q  <= dec_func;
            ex_ww_q    <= dec_ww;
            ex_rd_q    <= dec_rd;
            ex_imm_q   <= dec_imm;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_wr_en   = ex_wr_en_q;
    assign ex_rA_val  = ex_ra_q;
    assign ex_rB_val  = ex_rb_q;
    assign ex_Op_code = ex_op_q;
    assign ex_R_ins   = ex_func_q;
    assign ex_WW      = ex_ww_q;
    assign ex_rD      = ex_rd_q;
    assign ex_imm     = ex_imm_q;
endmodule
